// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU: next-PC selectors, fetch
// state encoding and default fetch-controller parameters.
package cpu_pkg;

    // Next-PC select codes driven by the control stage.
    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    // Defaults for the fetch controller.
    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF  = 1024;
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000_000C;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC generator plus legality checks for the fetch
// controller. Produces pc+4, the selected next-PC candidate, and whether
// the candidate (and pc+4 alone) lies inside instruction memory.
module npc_calc
    import cpu_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc4,
    output logic [31:0] npc,
    output logic        npc_ok,
    output logic        pc4_ok
);

    // Bounds widened to 33 bits so base + size cannot overflow.
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = IM_LO + 33'(IM_WORDS) * 33'd4;

    function automatic logic in_range(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) &&
               ({1'b0, addr} >= IM_LO) &&
               ({1'b0, addr} <  IM_HI);
    endfunction

    logic [31:0] br_off;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Select the next-PC candidate and check both it and pc+4 for legality.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        npc = pc4;
        unique case (npc_op)
            NPC_PC4: npc = pc4;
            NPC_BR:  npc = br_taken ? (pc4 + br_off) : pc4;
            NPC_J:   npc = {pc4[31:28], imm26, 2'b00};
            NPC_JR:  npc = rs_val;
            default: npc = pc4;
        endcase
        npc_ok = in_range(npc);
        pc4_ok = in_range(pc4);
    end

endmodule

// File: rtl/ifu_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences fetch through
// RUN/HALT/FAULT, forwards fetched words to decode and counts retired
// instructions. Instruction memory is combinational, so fetch has no latency.
module ifu_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
    parameter int unsigned IM_WORDS  = IM_WORDS_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    input  logic        resume,
    input  logic [31:0] instr_i,
    output logic [31:0] im_a,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] pc4, npc;
    logic        npc_ok, pc4_ok;
    logic        is_halt_word;

    npc_calc #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_npc_calc (
        .pc       (pc_q),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .pc4      (pc4),
        .npc      (npc),
        .npc_ok   (npc_ok),
        .pc4_ok   (pc4_ok)
    );

    assign is_halt_word = (instr_i == HALT_WORD);

    // Next-state, next-PC, fault capture and retire counting.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        retired_d  = retired_q;
        unique case (state_q)
            S_RUN: begin
                if (en) begin
                    if (is_halt_word) begin
                        state_d = S_HALT;
                    end else begin
                        // The instruction commits even when its target faults.
                        retired_d = retired_q + 32'd1;
                        if (npc_ok) begin
                            pc_d = npc;
                        end else begin
                            state_d    = S_FAULT;
                            fault_pc_d = npc;
                        end
                    end
                end
            end
            S_HALT: begin
                if (en && resume) begin
                    // The halting syscall retires when fetch resumes.
                    retired_d = retired_q + 32'd1;
                    if (pc4_ok) begin
                        state_d = S_RUN;
                        pc_d    = pc4;
                    end else begin
                        state_d    = S_FAULT;
                        fault_pc_d = pc4;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            state_q    <= S_RUN;
            pc_q       <= PC_RESET;
            fault_pc_q <= 32'h0;
            retired_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            retired_q  <= retired_d;
        end
    end

    assign im_a     = pc_q;
    assign pc_o     = pc_q;
    assign pc4_o    = pc4;
    assign instr_o  = (state_q == S_RUN && !is_halt_word) ? instr_i : 32'h0;
    assign halted   = (state_q == S_HALT);
    assign fault    = (state_q == S_FAULT);
    assign fault_pc = fault_pc_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_ifu_ctrl.sv
// Self-checking bench for ifu_ctrl: directed vector table, hand-written
// HALT/FAULT/enable sequences, and randomized stimulus against a
// behavioural model of the fetch rules.
module tb_ifu_ctrl;

    localparam logic [31:0] HALT    = 32'h0000_000C;
    localparam logic [31:0] NOP_IN  = 32'h2008_0001;
    localparam longint      BASE    = 64'h3000;
    localparam longint      WORDS   = 1024;

    logic        clk = 1'b0;
    logic        reset, en, br_taken, resume;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_val, instr_i;
    logic [31:0] im_a, instr_o, pc_o, pc4_o, fault_pc, retired;
    logic        halted, fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .resume   (resume),
        .instr_i  (instr_i),
        .im_a     (im_a),
        .instr_o  (instr_o),
        .pc_o     (pc_o),
        .pc4_o    (pc4_o),
        .halted   (halted),
        .fault    (fault),
        .fault_pc (fault_pc),
        .retired  (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset    = 1'b1;
        en       = 1'b1;
        npc_op   = 2'd0;
        br_taken = 1'b0;
        imm16    = 16'h0;
        imm26    = 26'h0;
        rs_val   = 32'h0;
        resume   = 1'b0;
        instr_i  = NOP_IN;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_fpc, m_ret;
    bit          m_halt, m_fault;

    function automatic bit legal(input logic [31:0] a);
        longint v = longint'(a);
        return (v % 4 == 0) && (v >= BASE) && (v < BASE + 4 * WORDS);
    endfunction

    function automatic logic [31:0] target(input logic [31:0] pc);
        longint seq = longint'(pc) + 4;
        case (npc_op)
            2'd1:    return br_taken ? 32'(seq + longint'($signed(imm16)) * 4) : 32'(seq);
            2'd2:    return 32'((seq & 64'hF000_0000) + longint'(imm26) * 4);
            2'd3:    return rs_val;
            default: return 32'(seq);
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] t;
        if (!reset) begin
            m_pc = 32'h3000; m_fpc = 0; m_ret = 0; m_halt = 0; m_fault = 0;
        end else if (m_fault) begin
            // terminal
        end else if (m_halt) begin
            if (en && resume) begin
                m_ret++;
                t = m_pc + 32'd4;
                if (legal(t)) begin m_pc = t; m_halt = 0; end
                else begin m_fault = 1; m_fpc = t; m_halt = 0; end
            end
        end else if (en) begin
            if (instr_i == HALT) m_halt = 1;
            else begin
                t = target(m_pc);
                m_ret++;
                if (legal(t)) m_pc = t;
                else begin m_fault = 1; m_fpc = t; end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] start_pc;
        logic [1:0]  op;
        logic        br;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic        x_fault;
        logic [31:0] x_pc;
        logic [31:0] x_fpc;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h3010, 2'd1, 1'b1, 16'hFFFC, 26'h0,       32'h0,    1'b0, 32'h3004, 32'h0};
        vecs[1]  = '{32'h3010, 2'd1, 1'b0, 16'hFFFC, 26'h0,       32'h0,    1'b0, 32'h3014, 32'h0};
        vecs[2]  = '{32'h3020, 2'd2, 1'b0, 16'h0,    26'h0000C10, 32'h0,    1'b0, 32'h3040, 32'h0};
        vecs[3]  = '{32'h3000, 2'd3, 1'b0, 16'h0,    26'h0,       32'h3002, 1'b1, 32'h3000, 32'h3002};
        vecs[4]  = '{32'h3000, 2'd3, 1'b0, 16'h0,    26'h0,       32'h4000, 1'b1, 32'h3000, 32'h4000};
        vecs[5]  = '{32'h3000, 2'd3, 1'b0, 16'h0,    26'h0,       32'h3FFC, 1'b0, 32'h3FFC, 32'h0};
        vecs[6]  = '{32'h3000, 2'd3, 1'b0, 16'h0,    26'h0,       32'h2FFC, 1'b1, 32'h3000, 32'h2FFC};
        vecs[7]  = '{32'h3000, 2'd1, 1'b1, 16'hFFFF, 26'h0,       32'h0,    1'b0, 32'h3000, 32'h0};
        vecs[8]  = '{32'h3000, 2'd1, 1'b1, 16'hFFFE, 26'h0,       32'h0,    1'b1, 32'h3000, 32'h2FFC};
        vecs[9]  = '{32'h3FFC, 2'd0, 1'b0, 16'h0,    26'h0,       32'h0,    1'b1, 32'h3FFC, 32'h4000};
        vecs[10] = '{32'h3000, 2'd2, 1'b0, 16'h0,    26'h0,       32'h0,    1'b1, 32'h3000, 32'h0};
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Reset state and sequential fetch.
        check("rst_pc", pc_o, 32'h3000);
        check("rst_im_a", im_a, 32'h3000);
        check("rst_pc4", pc4_o, 32'h3004);
        check("rst_retired", retired, 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_flags", {30'h0, halted, fault}, 32'h0);
        check("rst_instr_o", instr_o, NOP_IN);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("seq_pc%0d", i), pc_o, 32'h3000 + 32'(4 * i));
        end
        check("seq_retired", retired, 32'd3);

        // Table: jump to start_pc, apply one vector, compare.
        for (int v = 0; v < 11; v++) begin
            do_reset();
            npc_op = 2'd3; rs_val = vecs[v].start_pc;
            tick();
            npc_op = vecs[v].op; br_taken = vecs[v].br; imm16 = vecs[v].i16;
            imm26 = vecs[v].i26; rs_val = vecs[v].rs;
            tick();
            check($sformatf("vec%0d_pc", v), pc_o, vecs[v].x_pc);
            check($sformatf("vec%0d_fault", v), {31'h0, fault}, {31'h0, vecs[v].x_fault});
            check($sformatf("vec%0d_fault_pc", v), fault_pc, vecs[v].x_fpc);
            check($sformatf("vec%0d_retired", v), retired, 32'd2);
        end

        // FAULT is terminal until reset.
        do_reset();
        npc_op = 2'd3; rs_val = 32'h3002;
        tick();
        check("flt_fault", {31'h0, fault}, 32'h1);
        check("flt_instr_o", instr_o, 32'h0);
        npc_op = 2'd3; rs_val = 32'h3100; resume = 1'b1; instr_i = HALT;
        for (int i = 0; i < 4; i++) tick();
        check("flt_hold_pc", pc_o, 32'h3000);
        check("flt_hold_fpc", fault_pc, 32'h3002);
        check("flt_hold_ret", retired, 32'h1);
        check("flt_hold_flag", {31'h0, fault}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("flt_rst_pc", pc_o, 32'h3000);
        check("flt_rst_fault", {31'h0, fault}, 32'h0);
        check("flt_rst_ret", retired, 32'h0);
        check("flt_rst_fpc", fault_pc, 32'h0);

        // HALT: hold for 5 edges, ignore resume without en, then resume.
        do_reset();
        tick(); tick();
        instr_i = HALT;
        #1;
        check("halt_nop_run", instr_o, 32'h0);
        tick();
        check("halt_flag", {31'h0, halted}, 32'h1);
        npc_op = 2'd3; rs_val = 32'h3100;
        for (int i = 0; i < 5; i++) begin
            instr_i = $urandom;
            tick();
            check($sformatf("halt_pc%0d", i), pc_o, 32'h3008);
            check($sformatf("halt_instr%0d", i), instr_o, 32'h0);
        end
        check("halt_ret", retired, 32'd2);
        en = 1'b0; resume = 1'b1;
        tick();
        check("halt_noen", {31'h0, halted}, 32'h1);
        en = 1'b1; instr_i = NOP_IN;
        tick();
        resume = 1'b0; npc_op = 2'd0;
        check("resume_pc", pc_o, 32'h300C);
        check("resume_flag", {31'h0, halted}, 32'h0);
        check("resume_ret", retired, 32'd3);

        // en low freezes everything; instr_o still forwards.
        en = 1'b0; instr_i = 32'h1234_5678;
        for (int i = 0; i < 4; i++) tick();
        check("frz_pc", pc_o, 32'h300C);
        check("frz_ret", retired, 32'd3);
        check("frz_instr", instr_o, 32'h1234_5678);
        en = 1'b1;

        // Resume from HALT at the last legal word runs off the top.
        do_reset();
        npc_op = 2'd3; rs_val = 32'h3FFC;
        tick();
        instr_i = HALT;
        tick();
        instr_i = NOP_IN; resume = 1'b1;
        tick();
        check("top_fault", {30'h0, halted, fault}, 32'h1);
        check("top_fpc", fault_pc, 32'h4000);
        check("top_pc", pc_o, 32'h3FFC);

        // Reset in the middle of HALT.
        do_reset();
        instr_i = HALT;
        tick();
        check("rh_halted", {31'h0, halted}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1; instr_i = NOP_IN;
        check("rh_flags", {30'h0, halted, fault}, 32'h0);
        check("rh_pc", pc_o, 32'h3000);

        // Randomized run against the model.
        do_reset();
        m_pc = 32'h3000; m_fpc = 0; m_ret = 0; m_halt = 0; m_fault = 0;
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, m_fault ? 3 : 63) != 0);
            en       = ($urandom_range(0, 3) != 0);
            npc_op   = 2'($urandom_range(0, 3));
            br_taken = 1'($urandom);
            imm16    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
            imm26    = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'(32'h0C00 + $urandom_range(0, 32'h3FF));
            case ($urandom_range(0, 3))
                0:       rs_val = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
                1:       rs_val = $urandom;
                2:       rs_val = 32'h3000 + 32'($urandom_range(0, 4095));
                default: rs_val = ($urandom_range(0, 1) != 0) ? 32'h4000 : 32'h2FFC;
            endcase
            instr_i  = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            resume   = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd_im_a", im_a, m_pc);
            check("rnd_pc4", pc4_o, m_pc + 32'd4);
            check("rnd_instr_o", instr_o, (!m_halt && !m_fault && instr_i != HALT) ? instr_i : 32'h0);
            @(posedge clk);
            model_edge();
            #1;
            check("rnd_pc", pc_o, m_pc);
            check("rnd_flags", {30'h0, halted, fault}, {30'h0, m_halt, m_fault});
            check("rnd_fault_pc", fault_pc, m_fpc);
            check("rnd_retired", retired, m_ret);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_ctrl.md
Name: ifu_ctrl

Overview:
- Instruction-fetch controller for the single-cycle CPU. Owns the program counter, computes the next PC, drives the address of the combinational instruction memory and returns the fetched word.
- Sequences fetch through a run/halt/fault state machine and counts retired instructions.
- Sits between the instruction memory and the decode/control stage.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 1024, number of instruction-memory words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS).
- HALT_WORD, 32'h0000_000C, instruction encoding that halts fetch (syscall).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  advance enable; when low, all state holds.
- npc_op  in  2  next-PC select: 0 = PC+4, 1 = branch, 2 = jump, 3 = jump-register.
- br_taken  in  1  branch condition; only used when npc_op = 1.
- imm16  in  16  branch offset, in words.
- imm26  in  26  jump index.
- rs_val  in  32  jump-register target.
- resume  in  1  leave HALT.
- instr_i  in  32  word returned by the instruction memory.
- im_a  out  32  instruction-memory address; equals pc.
- instr_o  out  32  instruction to decode.
- pc_o  out  32  current PC.
- pc4_o  out  32  pc+4, used as the link value.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.
- fault_pc  out  32  rejected target address.
- retired  out  32  count of committed instructions.

Behaviour:
- Reset (reset==0 at a rising edge) overrides every other input and sets:
  - pc = PC_RESET, state = RUN
  - fault_pc = 0, retired = 0
- States are RUN, HALT and FAULT.
- Combinational outputs:
  - im_a = pc; pc_o = pc; pc4_o = pc + 4 (32-bit, wraps modulo 2^32).
  - instr_o = instr_i in RUN. It is 32'h0 (NOP) in HALT, in FAULT, and in RUN when instr_i == HALT_WORD.
- Next-PC candidate, npc:
  - npc_op = 0: pc+4.
  - npc_op = 1: pc+4 + (sign_ext(imm16) << 2) if br_taken, else pc+4.
  - npc_op = 2: {pc4[31:28], imm26, 2'b00}.
  - npc_op = 3: rs_val.
- npc is illegal if npc[1:0] != 0, or npc < IM_BASE, or npc >= IM_BASE + 4*IM_WORDS. Legality is checked with unsigned compares, widened to 33 bits to avoid overflow.
- RUN, en == 1 (priority top-down):
  - instr_i == HALT_WORD: go to HALT; pc and retired hold. npc_op is ignored in this cycle.
  - npc is illegal: go to FAULT; fault_pc = npc; pc holds; retired increments, because the faulting jump itself committed.
  - Otherwise: pc = npc; retired increments.
- RUN, en == 0: no change; instr_o still shows instr_i.
- HALT:
  - resume == 1 with en == 1: pc = pc+4, go to RUN, retired increments (the syscall retires).
  - resume while en == 0 is ignored.
  - pc+4 past the top of the legal range: go to FAULT with fault_pc = pc+4.
- FAULT: terminal. Only reset leaves it; all inputs are ignored.
- retired wraps from 32'hFFFF_FFFF to 0.
- Latency: a new PC is visible one clock after the committing edge. Instruction fetch has zero-cycle latency (combinational path im_a -> instr_i -> instr_o).
- Reset takes effect at the next rising edge, in any state, including mid-HALT and mid-FAULT.

Decomposition:
- Shared package cpu_pkg holds:
  - NPC_PC4, NPC_BR, NPC_J, NPC_JR localparams.
  - State encodings S_RUN, S_HALT, S_FAULT.
  - HALT_WORD and PC_RESET defaults.
- One natural sub-module, npc_calc: a purely combinational next-PC and legality checker. The PC register, FSM and counter stay in ifu_ctrl.

Test Plan:
- Reset then 3 edges with npc_op=0, en=1 -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; retired = 3.
- pc=0x3010, npc_op=1, br_taken=1, imm16=16'hFFFC -> pc becomes 0x3004.
- Same setup with br_taken=0 -> pc becomes 0x3014.
- pc=0x3020, npc_op=2, imm26=26'h0000C10 -> pc becomes 0x3040.
- npc_op=3, rs_val=0x3002 -> fault=1, fault_pc=0x3002, pc stays.
- Next: rs_val=0x4000 after a fresh reset -> fault_pc=0x4000. Further edges change nothing until reset is driven low.
- instr_i=0x0000000C at pc=0x3008 -> halted=1, instr_o=0, pc holds 0x3008 for 5 edges. Then resume=1 -> pc=0x300C, halted=0.
- In HALT, resume=1 with en=0 -> still halted.
- en=0 for 4 edges mid-run -> pc and retired frozen.
- reset low while in FAULT -> pc=0x3000, fault=0, retired=0 after one edge.
